// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//   Shares one SRAM-like memory port between instruction fetch (inst_*) and
//   data access (data_*). Requests are arbitrated in IDLE, and a granted
//   request is held (LOCK_I / LOCK_D) until the memory accepts it. In-order
//   responses are routed back using a tag FIFO of depth MAX_OUT
//   (tag 0 = inst, 1 = data).
//
//   Optional build macro: ARB_RR_EN
//     undefined : fixed data-over-inst priority
//     defined   : round-robin between the two sources when both request in
//                 IDLE, tracked by a 1-bit last_grant register

module sram_req_arbiter #(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    // Pointer width covers MAX_OUT slots; count must also represent MAX_OUT.
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            tag_mem [MAX_OUT];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            full;
    logic            sel_d;
    logic            push;
    logic            pop;
    logic            head;

`ifdef ARB_RR_EN
    logic            last_grant;
`endif

    assign full = (count == CW'(MAX_OUT));

    // Source selection and next-state: IDLE arbitrates, LOCK_x pins the grant
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        sel_d     = 1'b0;
        case (state)
            IDLE: begin
                if (!full) begin
`ifdef ARB_RR_EN
                    if (data_req && inst_req) begin
                        mem_req = 1'b1;
                        sel_d   = ~last_grant;
                    end else if (data_req) begin
                        mem_req = 1'b1;
                        sel_d   = 1'b1;
                    end else if (inst_req) begin
                        mem_req = 1'b1;
                        sel_d   = 1'b0;
                    end
`else
                    if (data_req) begin
                        mem_req = 1'b1;
                        sel_d   = 1'b1;
                    end else if (inst_req) begin
                        mem_req = 1'b1;
                        sel_d   = 1'b0;
                    end
`endif
                    if (mem_req && !mem_addr_ok) begin
                        state_nxt = sel_d ? LOCK_D : LOCK_I;
                    end
                end
            end
            LOCK_I: begin
                mem_req = 1'b1;
                sel_d   = 1'b0;
                if (mem_addr_ok) begin
                    state_nxt = IDLE;
                end
            end
            LOCK_D: begin
                mem_req = 1'b1;
                sel_d   = 1'b1;
                if (mem_addr_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Downstream request fields follow the selected source
    always_comb begin
        if (sel_d) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_wstrb = inst_wstrb;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end
    end

    // Handshake qualification; addr_ok without a request and data_ok with
    // nothing outstanding are both dropped here
    always_comb begin
        push         = mem_req && mem_addr_ok;
        pop          = mem_data_ok && (count != '0);
        head         = tag_mem[rd_ptr];
        inst_addr_ok = push && !sel_d;
        data_addr_ok = push &&  sel_d;
        inst_data_ok = pop  && !head;
        data_data_ok = pop  &&  head;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
        busy         = (count != '0) || (state != IDLE);
    end

    // Arbiter state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Tag FIFO: pointers wrap naturally since MAX_OUT is a power of two
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                tag_mem[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= sel_d;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Outstanding count; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef ARB_RR_EN
    // Remember which source was last accepted for round-robin
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b0;
        end else if (push) begin
            last_grant <= sel_d;
        end
    end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter
//   Directed bench for sram_req_arbiter (default build, MAX_OUT = 4).
//   Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.

module tb_sram_req_arbiter;

    logic        clk;
    logic        resetn;

    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    logic        busy;

    int n_cmp;
    int n_err;

    sram_req_arbiter #(.MAX_OUT(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One downstream response; exp_d selects which upstream strobe must fire
    task automatic resp(input string tag, input logic exp_d, input logic [31:0] rd);
        mem_data_ok = 1'b1;
        mem_rdata   = rd;
        #1;
        chk({tag, ".inst_data_ok"}, {31'd0, inst_data_ok}, {31'd0, ~exp_d});
        chk({tag, ".data_data_ok"}, {31'd0, data_data_ok}, {31'd0, exp_d});
        chk({tag, ".rdata"}, exp_d ? data_rdata : inst_rdata, rd);
        cyc();
        mem_data_ok = 1'b0;
    endtask

    // Single accepted request from one source in the current cycle
    task automatic acc(input string tag, input logic is_d, input logic [31:0] a);
        inst_req    = ~is_d;
        data_req    = is_d;
        inst_addr   = a;
        data_addr   = a;
        mem_addr_ok = 1'b1;
        #1;
        chk({tag, ".addr_ok"}, {30'd0, data_addr_ok, inst_addr_ok}, is_d ? 32'd2 : 32'd1);
        chk({tag, ".mem_addr"}, mem_addr, a);
        cyc();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetn      = 1'b0;
        inst_req    = 1'b0;
        inst_wr     = 1'b0;
        inst_size   = 2'd2;
        inst_wstrb  = 4'h0;
        inst_addr   = '0;
        inst_wdata  = '0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd2;
        data_wstrb  = 4'h0;
        data_addr   = '0;
        data_wdata  = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;

        // Reset state
        cyc();
        cyc();
        chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.oks", {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
        resetn = 1'b1;
        cyc();

        // Single fetch: accept in cycle 0, answer in cycle 2
        inst_req    = 1'b1;
        inst_addr   = 32'h1c000000;
        mem_addr_ok = 1'b1;
        #1;
        chk("fetch.inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        chk("fetch.mem_req", {31'd0, mem_req}, 32'd1);
        chk("fetch.mem_addr", mem_addr, 32'h1c000000);
        cyc();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        #1;
        chk("fetch.busy_c1", {31'd0, busy}, 32'd1);
        chk("fetch.no_data_c1", {31'd0, inst_data_ok}, 32'd0);
        cyc();
        resp("fetch.resp", 1'b0, 32'h02800413);
        #1;
        chk("fetch.busy_end", {31'd0, busy}, 32'd0);

        // Contention, fixed priority: data wins, inst follows next cycle
        inst_req    = 1'b1;
        inst_addr   = 32'h1c000004;
        data_req    = 1'b1;
        data_addr   = 32'h1c0000f0;
        data_wr     = 1'b1;
        data_wstrb  = 4'hf;
        data_wdata  = 32'hdeadbeef;
        mem_addr_ok = 1'b1;
        #1;
        chk("cont.mem_addr", mem_addr, 32'h1c0000f0);
        chk("cont.data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        chk("cont.inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        chk("cont.mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("cont.mem_wdata", mem_wdata, 32'hdeadbeef);
        chk("cont.mem_wstrb", {28'd0, mem_wstrb}, 32'hf);
        cyc();
        data_req = 1'b0;
        data_wr  = 1'b0;
        #1;
        chk("cont.inst_next", {30'd0, data_addr_ok, inst_addr_ok}, 32'd1);
        chk("cont.inst_addr", mem_addr, 32'h1c000004);
        chk("cont.inst_mem_wr", {31'd0, mem_wr}, 32'd0);
        cyc();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        resp("cont.r0", 1'b1, 32'h11111111);
        resp("cont.r1", 1'b0, 32'h22222222);

        // Lock hold: inst stalls for 3 cycles while data arrives
        inst_req  = 1'b1;
        inst_addr = 32'h1c000008;
        #1;
        chk("lock.c0_mem_addr", mem_addr, 32'h1c000008);
        chk("lock.c0_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd0);
        cyc();
        data_req  = 1'b1;
        data_addr = 32'h1c000100;
        #1;
        chk("lock.c1_mem_addr", mem_addr, 32'h1c000008);
        chk("lock.c1_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd0);
        chk("lock.c1_busy", {31'd0, busy}, 32'd1);
        cyc();
        #1;
        chk("lock.c2_mem_addr", mem_addr, 32'h1c000008);
        chk("lock.c2_mem_req", {31'd0, mem_req}, 32'd1);
        cyc();
        mem_addr_ok = 1'b1;
        #1;
        chk("lock.c3_mem_addr", mem_addr, 32'h1c000008);
        chk("lock.c3_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd1);
        cyc();
        inst_req = 1'b0;
        #1;
        chk("lock.c4_data_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd2);
        chk("lock.c4_mem_addr", mem_addr, 32'h1c000100);
        cyc();
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        resp("lock.r0", 1'b0, 32'h33333333);
        resp("lock.r1", 1'b1, 32'h44444444);

        // Full / wrap: four outstanding (I,D,I,D), write pointer already offset
        acc("full.a0", 1'b0, 32'h1c001000);
        acc("full.a1", 1'b1, 32'h1c001004);
        acc("full.a2", 1'b0, 32'h1c001008);
        acc("full.a3", 1'b1, 32'h1c00100c);
        inst_req    = 1'b1;
        inst_addr   = 32'h1c001010;
        mem_addr_ok = 1'b1;
        #1;
        chk("full.mem_req", {31'd0, mem_req}, 32'd0);
        chk("full.stray_addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd0);
        // Pop while still full: no selection this cycle
        resp("full.r0", 1'b0, 32'h50000000);
        #1;
        // Fifth request accepted together with a pop
        chk("full.fifth_ok", {31'd0, inst_addr_ok}, 32'd1);
        resp("full.r1", 1'b1, 32'h50000001);
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        acc("full.a5", 1'b1, 32'h1c001014);
        inst_req = 1'b1;
        #1;
        chk("full.again_mem_req", {31'd0, mem_req}, 32'd0);
        cyc();
        inst_req = 1'b0;
        resp("full.r2", 1'b0, 32'h50000002);
        resp("full.r3", 1'b1, 32'h50000003);
        resp("full.r4", 1'b0, 32'h50000004);
        resp("full.r5", 1'b1, 32'h50000005);
        #1;
        chk("full.busy_end", {31'd0, busy}, 32'd0);
        cyc();

        // Response routing D, I, D then a stray response
        acc("route.a0", 1'b1, 32'h1c002000);
        acc("route.a1", 1'b0, 32'h1c002004);
        acc("route.a2", 1'b1, 32'h1c002008);
        resp("route.r0", 1'b1, 32'h60000000);
        resp("route.r1", 1'b0, 32'h60000001);
        resp("route.r2", 1'b1, 32'h60000002);
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h6000dead;
        #1;
        chk("route.stray", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        cyc();
        mem_data_ok = 1'b0;
        #1;
        chk("route.stray_busy", {31'd0, busy}, 32'd0);

        // Both requesting continuously: data granted every cycle
        inst_req    = 1'b1;
        data_req    = 1'b1;
        inst_addr   = 32'h1c003000;
        data_addr   = 32'h1c003100;
        mem_addr_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("prio.grant", {30'd0, data_addr_ok, inst_addr_ok}, 32'd2);
            cyc();
        end
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        resp("prio.r0", 1'b1, 32'h70000000);
        resp("prio.r1", 1'b1, 32'h70000001);
        resp("prio.r2", 1'b1, 32'h70000002);

        // Reset mid-operation discards outstanding tags
        acc("mrst.a0", 1'b0, 32'h1c004000);
        resetn = 1'b0;
        #1;
        chk("mrst.busy", {31'd0, busy}, 32'd0);
        cyc();
        resetn = 1'b1;
        cyc();
        mem_data_ok = 1'b1;
        #1;
        chk("mrst.stray", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        cyc();
        mem_data_ok = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
